// File: rtl/tmr_voter_monitor.sv
// Triple-modular-redundancy voter with per-lane fault tracking.
// Votes three redundant lanes into one registered word, degrading gracefully as lanes are declared faulty.
module tmr_voter_monitor #(
    parameter int WIDTH        = 8,
    parameter int FAULT_THRESH = 4,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic             clr_fault,
    output logic [WIDTH-1:0] y,
    output logic             y_valid,
    output logic [2:0]       mism,
    output logic [2:0]       fault,
    output logic             uncorr,
    output logic             dead,
    output logic [CNT_W-1:0] err_total
);

    localparam int CW = $clog2(FAULT_THRESH + 1);

    function automatic logic [CW-1:0] cnt_sat_inc(input logic [CW-1:0] v);
        return (v >= CW'(FAULT_THRESH)) ? v : v + 1'b1;
    endfunction

    function automatic logic [CNT_W-1:0] err_sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic [WIDTH-1:0]       maj;
    logic                   mode_dead;
    logic                   mode_degr;
    logic                   vld_p0;
    logic [WIDTH-1:0]       y_p0;
    logic [2:0]             mism_p0;
    logic                   uncorr_p0;
    logic [WIDTH-1:0]       h_lo;
    logic [WIDTH-1:0]       h_hi;
    logic [2:0]             healthy;
    logic [2:0][CW-1:0]     cnt;
    logic [2:0][CW-1:0]     cnt_nxt;
    logic [2:0]             fault_nxt;
    logic [CNT_W-1:0]       err_nxt;

    assign maj       = (a & b) | (b & c) | (a & c);
    assign mode_dead = (fault[0] & fault[1]) | (fault[1] & fault[2]) | (fault[0] & fault[2]);
    assign mode_degr = (|fault) & ~mode_dead;
    assign dead      = mode_dead;
    assign vld_p0    = in_valid;

    // Stage p0: vote in the mode selected by the fault flags held before this edge
    always_comb begin
        y_p0      = y;
        mism_p0   = 3'b000;
        uncorr_p0 = 1'b0;
        h_lo      = a;
        h_hi      = b;
        healthy   = 3'b011;
        case (fault)
            3'b001: begin h_lo = b; h_hi = c; healthy = 3'b110; end
            3'b010: begin h_lo = a; h_hi = c; healthy = 3'b101; end
            default: begin h_lo = a; h_hi = b; healthy = 3'b011; end
        endcase
        if (mode_dead) begin
            uncorr_p0 = 1'b1;
        end else if (mode_degr) begin
            if (h_lo == h_hi) begin
                y_p0 = h_lo;
            end else begin
                uncorr_p0 = 1'b1;
                mism_p0   = healthy;
            end
        end else begin
            y_p0       = maj;
            mism_p0[0] = (a != maj);
            mism_p0[1] = (b != maj);
            mism_p0[2] = (c != maj);
            uncorr_p0  = (mism_p0[0] & mism_p0[1]) | (mism_p0[1] & mism_p0[2]) |
                         (mism_p0[0] & mism_p0[2]);
        end
    end

    // Faulted lanes freeze their counters; a clear pulse overrides anything this sample would do
    always_comb begin
        fault_nxt = fault;
        cnt_nxt   = cnt;
        for (int i = 0; i < 3; i++) begin
            if (vld_p0 && !fault[i]) begin
                cnt_nxt[i] = mism_p0[i] ? cnt_sat_inc(cnt[i]) : '0;
                if (cnt_nxt[i] == CW'(FAULT_THRESH)) fault_nxt[i] = 1'b1;
            end
        end
        if (clr_fault) begin
            fault_nxt = 3'b000;
            cnt_nxt   = '0;
        end
        err_nxt = err_total;
        if (vld_p0 && ((|mism_p0) || uncorr_p0)) err_nxt = err_sat_inc(err_total);
    end

    // Stage p1: registered vote results and monitor state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y         <= '0;
            y_valid   <= 1'b0;
            mism      <= 3'b000;
            uncorr    <= 1'b0;
            fault     <= 3'b000;
            cnt       <= '0;
            err_total <= '0;
        end else begin
            y_valid   <= vld_p0;
            mism      <= vld_p0 ? mism_p0 : 3'b000;
            uncorr    <= vld_p0 & uncorr_p0;
            if (vld_p0) y <= y_p0;
            fault     <= fault_nxt;
            cnt       <= cnt_nxt;
            err_total <= err_nxt;
        end
    end

endmodule

// File: tb/tb_tmr_voter_monitor.sv
// Directed bench for tmr_voter_monitor (WIDTH=8, FAULT_THRESH=4, CNT_W=16).
// Inputs change 1ns after the rising edge; outputs are checked at that same point.
module tb_tmr_voter_monitor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [7:0]  a, b, c;
    logic        clr_fault;
    logic [7:0]  y;
    logic        y_valid;
    logic [2:0]  mism;
    logic [2:0]  fault;
    logic        uncorr;
    logic        dead;
    logic [15:0] err_total;

    int n_chk = 0;
    int n_err = 0;

    tmr_voter_monitor #(.WIDTH(8), .FAULT_THRESH(4), .CNT_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .c         (c),
        .clr_fault (clr_fault),
        .y         (y),
        .y_valid   (y_valid),
        .mism      (mism),
        .fault     (fault),
        .uncorr    (uncorr),
        .dead      (dead),
        .err_total (err_total)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic v, input logic [7:0] ia, input logic [7:0] ib,
                        input logic [7:0] ic, input logic clr);
        in_valid  = v;
        a         = ia;
        b         = ib;
        c         = ic;
        clr_fault = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic yv_e, input logic [7:0] y_e,
                              input logic [2:0] m_e, input logic u_e, input logic [2:0] f_e,
                              input logic d_e, input logic [15:0] e_e);
        check({tag, ".y_valid"}, 64'(y_valid), 64'(yv_e));
        check({tag, ".y"},       64'(y),       64'(y_e));
        check({tag, ".mism"},    64'(mism),    64'(m_e));
        check({tag, ".uncorr"},  64'(uncorr),  64'(u_e));
        check({tag, ".fault"},   64'(fault),   64'(f_e));
        check({tag, ".dead"},    64'(dead),    64'(d_e));
        check({tag, ".err"},     64'(err_total), 64'(e_e));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        step(1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
        expect_out("reset", 1'b0, 8'h00, 3'b000, 1'b0, 3'b000, 1'b0, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Clean and corrected samples in FULL mode
        step(1'b1, 8'h5A, 8'h5A, 8'h5A, 1'b0);
        expect_out("clean", 1'b1, 8'h5A, 3'b000, 1'b0, 3'b000, 1'b0, 16'd0);
        step(1'b0, 8'hFF, 8'h00, 8'h0F, 1'b0);
        expect_out("idle", 1'b0, 8'h5A, 3'b000, 1'b0, 3'b000, 1'b0, 16'd0);
        step(1'b1, 8'hFF, 8'h00, 8'h0F, 1'b0);
        expect_out("split", 1'b1, 8'h0F, 3'b011, 1'b1, 3'b000, 1'b0, 16'd1);
        step(1'b1, 8'h00, 8'h00, 8'h00, 1'b0);
        expect_out("zero", 1'b1, 8'h00, 3'b000, 1'b0, 3'b000, 1'b0, 16'd1);

        // Lane B faults after four consecutive mismatches
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 8'h00, 8'h01, 8'h00, 1'b0);
            expect_out($sformatf("bfault%0d", i), 1'b1, 8'h00, 3'b010, 1'b0,
                       (i == 3) ? 3'b010 : 3'b000, 1'b0, 16'(2 + i));
        end
        step(1'b1, 8'h10, 8'h01, 8'h00, 1'b0);
        expect_out("degr_split", 1'b1, 8'h00, 3'b101, 1'b1, 3'b010, 1'b0, 16'd6);
        step(1'b1, 8'h33, 8'hFF, 8'h33, 1'b0);
        expect_out("degr_agree", 1'b1, 8'h33, 3'b000, 1'b0, 3'b010, 1'b0, 16'd6);
        step(1'b0, 8'h00, 8'h00, 8'h00, 1'b1);
        expect_out("clr", 1'b0, 8'h33, 3'b000, 1'b0, 3'b000, 1'b0, 16'd6);
        step(1'b1, 8'h11, 8'h11, 8'h22, 1'b0);
        expect_out("full_again", 1'b1, 8'h11, 3'b100, 1'b0, 3'b000, 1'b0, 16'd7);
        step(1'b1, 8'h00, 8'h00, 8'h00, 1'b0);
        expect_out("zero2", 1'b1, 8'h00, 3'b000, 1'b0, 3'b000, 1'b0, 16'd7);

        // A match between mismatch bursts restarts lane A's count
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 8'h01, 8'h00, 8'h00, 1'b0);
            expect_out($sformatf("aburst1_%0d", i), 1'b1, 8'h00, 3'b001, 1'b0, 3'b000, 1'b0, 16'(8 + i));
        end
        step(1'b1, 8'h00, 8'h00, 8'h00, 1'b0);
        expect_out("amatch", 1'b1, 8'h00, 3'b000, 1'b0, 3'b000, 1'b0, 16'd10);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 8'h01, 8'h00, 8'h00, 1'b0);
            expect_out($sformatf("aburst2_%0d", i), 1'b1, 8'h00, 3'b001, 1'b0, 3'b000, 1'b0, 16'(11 + i));
        end
        step(1'b1, 8'h00, 8'h00, 8'h00, 1'b0);
        expect_out("zero3", 1'b1, 8'h00, 3'b000, 1'b0, 3'b000, 1'b0, 16'd13);

        // clr_fault on the edge of lane B's 4th mismatch wins over the set
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 8'h00, 8'h01, 8'h00, 1'b0);
            expect_out($sformatf("bpre%0d", i), 1'b1, 8'h00, 3'b010, 1'b0, 3'b000, 1'b0, 16'(14 + i));
        end
        step(1'b1, 8'h00, 8'h01, 8'h00, 1'b1);
        expect_out("bclr_race", 1'b1, 8'h00, 3'b010, 1'b0, 3'b000, 1'b0, 16'd17);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 8'h00, 8'h01, 8'h00, 1'b0);
            expect_out($sformatf("bpost%0d", i), 1'b1, 8'h00, 3'b010, 1'b0,
                       (i == 3) ? 3'b010 : 3'b000, 1'b0, 16'(18 + i));
        end
        step(1'b0, 8'h00, 8'h00, 8'h00, 1'b1);
        expect_out("clr2", 1'b0, 8'h00, 3'b000, 1'b0, 3'b000, 1'b0, 16'd21);

        // Lanes A and C fault together -> dead
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 8'h01, 8'h00, 8'h02, 1'b0);
            expect_out($sformatf("acfault%0d", i), 1'b1, 8'h00, 3'b101, 1'b1,
                       (i == 3) ? 3'b101 : 3'b000, (i == 3), 16'(22 + i));
        end
        step(1'b1, 8'h77, 8'h77, 8'h77, 1'b0);
        expect_out("dead0", 1'b1, 8'h00, 3'b000, 1'b1, 3'b101, 1'b1, 16'd26);
        step(1'b1, 8'h55, 8'h55, 8'h55, 1'b0);
        expect_out("dead1", 1'b1, 8'h00, 3'b000, 1'b1, 3'b101, 1'b1, 16'd27);
        step(1'b1, 8'h66, 8'h66, 8'h66, 1'b0);

        // Asynchronous reset mid-stream, then FULL mode again
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        expect_out("async_rst", 1'b0, 8'h00, 3'b000, 1'b0, 3'b000, 1'b0, 16'd0);
        #1;
        rst_n = 1'b1;
        step(1'b1, 8'h01, 8'h01, 8'h00, 1'b0);
        expect_out("post_rst", 1'b1, 8'h01, 3'b100, 1'b0, 3'b000, 1'b0, 16'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/tmr_voter_monitor.md
TMR_VOTER_MONITOR -- requirements
Module: tmr_voter_monitor

Interface
REQ-001 Parameter WIDTH, default 8, bit width of each redundant lane and of the voted output (legal range 1..64).
REQ-002 Parameter FAULT_THRESH, default 4, number of consecutive valid-cycle mismatches that declares a lane faulty (legal range 1..255).
REQ-003 Parameter CNT_W, default 16, width of the total-error counter.
REQ-004 Ports (clock and reset first):
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  lanes a/b/c carry a sample this cycle.
- a  in  WIDTH  lane A.
- b  in  WIDTH  lane B.
- c  in  WIDTH  lane C.
- clr_fault  in  1  one-cycle pulse; clears fault flags and the consecutive-mismatch counters.
- y  out  WIDTH  registered voted word.
- y_valid  out  1  y updated this cycle.
- mism  out  3  registered per-lane mismatch vs. voted word, {C,B,A}.
- fault  out  3  sticky per-lane fault flags, {C,B,A}.
- uncorr  out  1  registered: current sample could not be corrected.
- dead  out  1  combinational: two or more fault bits set.
- err_total  out  CNT_W  saturating count of valid samples with any mismatch or uncorr.

Function
REQ-005 Latency is exactly 1 cycle: a sample with in_valid=1 on edge k SHALL appear on y, y_valid=1, mism and uncorr after edge k.
REQ-006 With in_valid=0, y SHALL hold, y_valid/mism/uncorr SHALL be 0, and the counters and fault SHALL not change.
REQ-007 Mode select SHALL use the fault register value before the edge (flags set on edge k take effect for the sample on edge k+1).
REQ-008 Mode FULL (no fault bits): y SHALL be the bitwise majority (a&b)|(b&c)|(a&c); mism[i]=1 iff lane i differs from the majority in any bit; uncorr=1 iff two or more mism bits are set.
REQ-009 Mode DEGRADED (exactly one fault bit): the faulted lane is excluded; if the two healthy lanes are equal, y SHALL take their value and uncorr=0; otherwise y SHALL hold its previous value, uncorr=1, and mism SHALL be set for both healthy lanes; mism of the faulted lane SHALL be 0.
REQ-010 Mode DEAD (two or more fault bits): y SHALL hold, y_valid=1, uncorr=1, mism=0.
REQ-011 Per-lane consecutive counter (width clog2(FAULT_THRESH+1)): on a valid sample it SHALL increment, saturating at FAULT_THRESH, if the lane mismatched, and clear to 0 if it matched; faulted lanes' counters SHALL hold.
REQ-012 fault[i] SHALL set on the edge where counter i reaches FAULT_THRESH and SHALL remain set until clr_fault or reset.
REQ-013 clr_fault=1 SHALL clear all fault bits and consecutive counters on that edge; if it coincides with a valid sample, the sample is voted in the pre-clear mode, and clear wins over any count or set from that sample.
REQ-014 err_total SHALL increment by 1 on each valid sample with any mism or uncorr set, saturate at 2^CNT_W-1, and be cleared only by reset (not by clr_fault).

Reset
REQ-015 While rst_n=0, all of y, y_valid, mism, fault, uncorr, err_total and the internal counters SHALL be 0 immediately, independent of clk.
REQ-016 After rst_n rises, the first valid sample SHALL be voted in FULL mode.

Verification (WIDTH=8, FAULT_THRESH=4, CNT_W=16)
REQ-017 Valid sample a=b=c=0x5A -> next cycle: y=0x5A, y_valid=1, mism=000, uncorr=0, err_total unchanged.
REQ-018 a=0xFF, b=0x00, c=0x0F -> y=0x0F, mism=011, uncorr=1, err_total+1.
REQ-019 Four consecutive valid samples with b=0x01, a=c=0x00 -> y=0x00 each cycle, mism=010, fault=010 after the 4th edge. A 5th sample with a=0x10, c=0x00 -> y holds 0x00, uncorr=1, mism=101. Pulse clr_fault -> fault=000, FULL mode resumes.
REQ-020 Three mismatches on lane A, one match, then three mismatches -> fault[0] stays 0 (counter cleared by the match).
REQ-021 Drive lanes A and C to fault -> dead=1; the subsequent valid samples hold y, uncorr=1. Assert rst_n=0 mid-stream between edges -> all outputs 0 at once, and the next valid sample is voted in FULL mode.
REQ-022 Assert clr_fault on the same edge that lane B's 4th mismatch arrives -> fault=000, and lane B's counter is 0.
